hcsr04_echo_timer: RTL and testbench

Upstream measurement front-end for the HC-SR04 ultrasonic sensor on the Tang Nano 9K hackathon board.
- Generates the TRIG pulse and synchronises the ECHO input.
- Times the echo pulse width and converts it to whole centimetres without a divider.
- Presents a registered distance with a one-cycle valid strobe, which drives the LED, seven-segment and LCD visualisation stages.
- Owns measurement period and timeout policy, so downstream stages never see stale or garbage values.

---
 rtl/hcsr04_pkg.sv | 19 +
 rtl/us_tick_gen.sv | 36 +++
 rtl/hcsr04_echo_timer.sv | 175 +++++++++++++++++
 tb/tb_hcsr04_echo_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hcsr04_pkg.sv
// Shared types and constants for the HC-SR04 echo timer.
// Counter widths are derived from the largest value each counter must hold.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StHoldoff
    } state_e;

    localparam int unsigned US_PER_CM = 58;

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every DIV clocks, restartable by clear_i.
module us_tick_gen
    import hcsr04_pkg::*;
#(
    parameter int unsigned DIV = 27
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned W = cnt_w(DIV - 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Left ungated by clear_i; the FSM discards counts on the restart cycle anyway.
    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/hcsr04_echo_timer.sv
// HC-SR04 front-end: TRIG generation, ECHO synchronisation and pulse-width to
// centimetre conversion with period and timeout policy.
module hcsr04_echo_timer
    import hcsr04_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 27_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_US  = 60_000,
    parameter int unsigned TIMEOUT_US = 30_000,
    parameter int unsigned DIST_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] distance,
    output logic              distance_valid,
    output logic              timeout_err,
    output logic              busy
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned US_W  = cnt_w(PERIOD_US);
    localparam int unsigned PRE_W = cnt_w(US_PER_CM - 1);

    localparam logic [US_W-1:0]  TRIG_CNT   = US_W'(TRIG_US);
    localparam logic [US_W-1:0]  TOUT_CNT   = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0]  PERIOD_CNT = US_W'(PERIOD_US);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(US_PER_CM - 1);

    state_e              state_q, state_d;
    logic [US_W-1:0]     us_cnt_q, us_cnt_d, us_inc;
    logic [PRE_W-1:0]    cm_pre_q, cm_pre_d;
    logic [DIST_W-1:0]   cm_cnt_q, cm_cnt_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic [1:0]          sync_q, sync_d;
    logic                prev_q, prev_d;
    logic                trig_q, trig_d;
    logic                valid_q, valid_d;
    logic                tout_q, tout_d;
    logic                busy_q, busy_d;
    logic                us_tick, start, echo_rise, echo_fall;

    us_tick_gen #(
        .DIV (DIV)
    ) u_us_tick_gen (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (start),
        .tick_o  (us_tick)
    );

    assign echo_rise = sync_q[1] & ~prev_q;
    assign echo_fall = ~sync_q[1] & prev_q;
    assign us_inc    = us_cnt_q + US_W'(us_tick);

    always_comb begin
        sync_d   = {sync_q[0], echo};
        prev_d   = sync_q[1];
        state_d  = state_q;
        us_cnt_d = us_cnt_q;
        cm_pre_d = cm_pre_q;
        cm_cnt_d = cm_cnt_q;
        trig_d   = trig_q;
        dist_d   = dist_q;
        valid_d  = 1'b0;
        tout_d   = 1'b0;
        start    = 1'b0;

        if (state_q != StIdle) begin
            us_cnt_d = us_inc;
        end

        // 58 us of echo per centimetre; cm_cnt sticks at all-ones.
        if (state_q == StMeasure && us_tick) begin
            if (cm_pre_q == PRE_LAST) begin
                cm_pre_d = '0;
                if (cm_cnt_q != '1) begin
                    cm_cnt_d = cm_cnt_q + 1'b1;
                end
            end else begin
                cm_pre_d = cm_pre_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                start = enable;
            end
            StTrig: begin
                if (us_inc == TRIG_CNT) begin
                    trig_d  = 1'b0;
                    state_d = StWaitRise;
                end
            end
            StWaitRise: begin
                if (echo_rise) begin
                    state_d = StMeasure;
                end else if (us_inc >= TOUT_CNT) begin
                    tout_d  = 1'b1;
                    state_d = StHoldoff;
                end
            end
            StMeasure: begin
                // A fall coinciding with the timeout still counts as a good reading.
                if (echo_fall) begin
                    dist_d  = cm_cnt_d;
                    valid_d = 1'b1;
                    state_d = StHoldoff;
                end else if (us_inc >= TOUT_CNT) begin
                    tout_d  = 1'b1;
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if (us_inc >= PERIOD_CNT) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d  = StTrig;
            trig_d   = 1'b1;
            us_cnt_d = '0;
            cm_pre_d = '0;
            cm_cnt_d = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            us_cnt_q <= '0;
            cm_pre_q <= '0;
            cm_cnt_q <= '0;
            dist_q   <= '0;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            trig_q   <= 1'b0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            us_cnt_q <= us_cnt_d;
            cm_pre_q <= cm_pre_d;
            cm_cnt_q <= cm_cnt_d;
            dist_q   <= dist_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            trig_q   <= trig_d;
            valid_q  <= valid_d;
            tout_q   <= tout_d;
            busy_q   <= busy_d;
        end
    end

    assign trig           = trig_q;
    assign distance       = dist_q;
    assign distance_valid = valid_q;
    assign timeout_err    = tout_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_hcsr04_echo_timer.sv
// Bench for hcsr04_echo_timer: a 16-bit and a 4-bit instance share stimulus and
// are checked against a pulse-width/58 reference with saturation and timing rules.
module tb_hcsr04_echo_timer;

    localparam int CLK_HZ      = 2_000_000;
    localparam int DIV         = CLK_HZ / 1_000_000;
    localparam int TRIG_US     = 10;
    localparam int TIMEOUT_US  = 1_400;
    localparam int PERIOD_US   = 1_600;
    localparam int TRIG_CYC    = TRIG_US * DIV;
    localparam int TIMEOUT_CYC = TIMEOUT_US * DIV;
    localparam int PERIOD_CYC  = PERIOD_US * DIV;

    localparam int K_ECHO  = 0;
    localparam int K_NONE  = 1;
    localparam int K_STUCK = 2;

    typedef struct {
        int kind;
        int delay_us;
        int width_us;
        bit drop;
    } meas_t;

    typedef struct {
        bit valid;
        int dist16;
        int dist4;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        echo = 1'b0;
    logic        trig, valid16, tout16, busy16;
    logic        trig4, valid4, tout4, busy4;
    logic [15:0] dist16;
    logic [3:0]  dist4;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int n_valid = 0, n_tout = 0, n_valid4 = 0, n_tout4 = 0;
    int v_cyc = 0, t_cyc = 0;
    int good16 = 0, good4 = 0;
    int prev_rise = 0;
    bit have_prev = 1'b0;
    meas_t vecs[16];

    hcsr04_echo_timer #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US), .DIST_W(16)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
        .distance(dist16), .distance_valid(valid16), .timeout_err(tout16), .busy(busy16)
    );

    hcsr04_echo_timer #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US), .DIST_W(4)
    ) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .echo(echo), .trig(trig4),
        .distance(dist4), .distance_valid(valid4), .timeout_err(tout4), .busy(busy4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid16) begin n_valid++; v_cyc = cyc; end
        if (tout16)  begin n_tout++;  t_cyc = cyc; end
        if (valid4)  n_valid4++;
        if (tout4)   n_tout4++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input meas_t v, input int last16, input int last4);
        exp_t e;
        int cm;
        if (v.kind != K_ECHO) begin
            e.valid = 1'b0;
            e.dist16 = last16;
            e.dist4 = last4;
        end else begin
            cm = v.width_us / 58;
            e.valid = 1'b1;
            e.dist16 = (cm > 65535) ? 65535 : cm;
            e.dist4 = (cm > 15) ? 15 : cm;
        end
        return e;
    endfunction

    task automatic run_meas(input meas_t v);
        exp_t e;
        int n, rise_c, fall_c, fc, half;
        int b_v, b_t, b_v4, b_t4;
        e = model(v, good16, good4);
        b_v = n_valid; b_t = n_tout; b_v4 = n_valid4; b_t4 = n_tout4;
        fc = 0;
        if (v.kind == K_STUCK) echo = 1'b1;
        n = 0;
        while (!trig && n < 2 * PERIOD_CYC) begin @(negedge clock); n++; end
        if (!trig) begin
            check("trig_rise_seen", 0, 1);
            echo = 1'b0;
            have_prev = 1'b0;
            return;
        end
        rise_c = cyc;
        if (have_prev) check("trig_period", rise_c - prev_rise, PERIOD_CYC);
        prev_rise = rise_c;
        have_prev = 1'b1;
        check("trig4_match", int'(trig4), 1);
        n = 0;
        while (trig && n < 4 * TRIG_CYC) begin @(negedge clock); n++; end
        fall_c = cyc;
        check("trig_width", fall_c - rise_c, TRIG_CYC);
        if (v.kind == K_ECHO) begin
            repeat (v.delay_us * DIV) @(negedge clock);
            echo = 1'b1;
            half = (v.width_us * DIV) / 2;
            repeat (half) @(negedge clock);
            if (v.drop) enable = 1'b0;
            repeat (v.width_us * DIV - half) @(negedge clock);
            echo = 1'b0;
            fc = cyc;
        end
        while (cyc < rise_c + TIMEOUT_CYC + 4) @(negedge clock);
        check("valid_pulses", n_valid - b_v, e.valid ? 1 : 0);
        check("timeout_pulses", n_tout - b_t, e.valid ? 0 : 1);
        check("valid4_pulses", n_valid4 - b_v4, e.valid ? 1 : 0);
        check("timeout4_pulses", n_tout4 - b_t4, e.valid ? 0 : 1);
        if (e.valid) check("valid_latency", v_cyc - fc, 3);
        else         check("timeout_at", t_cyc - rise_c, TIMEOUT_CYC);
        check("distance16", int'(dist16), e.dist16);
        check("distance4", int'(dist4), e.dist4);
        check("busy_holdoff", int'(busy16), 1);
        good16 = e.dist16;
        good4 = e.dist4;
        echo = 1'b0;
    endtask

    initial begin
        int n, b_v, b_t;

        vecs[0]  = '{K_ECHO, 100, 580, 1'b0};
        vecs[1]  = '{K_NONE, 0, 0, 1'b0};
        vecs[2]  = '{K_STUCK, 0, 0, 1'b0};
        vecs[3]  = '{K_STUCK, 0, 0, 1'b0};
        vecs[4]  = '{K_ECHO, 100, 1160, 1'b0};
        vecs[5]  = '{K_ECHO, 50, 1200, 1'b0};
        vecs[6]  = '{K_ECHO, 30, 57, 1'b0};
        vecs[7]  = '{K_ECHO, 30, 58, 1'b0};
        vecs[8]  = '{K_ECHO, 30, 1217, 1'b0};
        for (int i = 9; i < 15; i++) begin
            vecs[i].kind = ($urandom_range(0, 4) == 0) ? K_NONE : K_ECHO;
            vecs[i].delay_us = int'($urandom_range(1, 100));
            vecs[i].width_us = int'($urandom_range(1, 1250));
            vecs[i].drop = 1'b0;
        end
        vecs[15] = '{K_ECHO, 40, 1160, 1'b1};

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_trig", int'(trig), 0);
        check("rst_distance", int'(dist16), 0);
        check("rst_valid", int'(valid16), 0);
        check("rst_timeout", int'(tout16), 0);
        check("rst_busy", int'(busy16), 0);

        // Reset asserted in the middle of TRIG.
        reset = 1'b0;
        enable = 1'b1;
        n = 0;
        while (!trig && n < 20) begin @(negedge clock); n++; end
        check("pre_reset_trig", int'(trig), 1);
        repeat (5) @(negedge clock);
        b_v = n_valid; b_t = n_tout;
        #2 reset = 1'b1;
        #1;
        check("async_trig", int'(trig), 0);
        check("async_busy", int'(busy16), 0);
        check("async_distance", int'(dist16), 0);
        repeat (3) @(negedge clock);
        check("reset_strobes", (n_valid - b_v) + (n_tout - b_t), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_meas(vecs[i]);

        // Enable dropped mid-MEASURE: result delivered above, then no new trigger.
        while (cyc < prev_rise + PERIOD_CYC + 5) @(negedge clock);
        check("idle_busy", int'(busy16), 0);
        check("idle_busy4", int'(busy4), 0);
        check("idle_trig", int'(trig), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
